// File: rtl/adres_yonlendirici.sv
// adres_yonlendirici
// Routes a single core load/store request to one of BOLGE_SAYISI slave
// regions. A region hits when (address & mask) == base, and the lowest index
// wins on overlap. One transaction is outstanding at a time. An unmapped
// address or a slave that exceeds ZAMAN_ASIMI cycles produces an error
// response.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   istek_*                       core request (valid/ready) with addr/write/data/byte-enables
//   yanit_*                       one-cycle response pulse to the core (data, error)
//   bolge_gecerli_o/hazir_i       one-hot slave request handshake
//   bolge_adres/yaz/veri/maske_o  latched request, shared by all slaves
//   bolge_yanit_gecerli_i/veri_i  per-slave response valid and packed read data
module adres_yonlendirici #(
  parameter int BOLGE_SAYISI = 2,
  parameter int ADRES_BIT    = 32,
  parameter int VERI_BIT     = 32,
  parameter logic [BOLGE_SAYISI*ADRES_BIT-1:0] BOLGE_TABAN = {32'h0000_0000, 32'h4000_0000},
  parameter logic [BOLGE_SAYISI*ADRES_BIT-1:0] BOLGE_MASKE = {32'h4000_0000, 32'h4000_0000},
  parameter int ZAMAN_ASIMI  = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             istek_gecerli_i,
  output logic                             istek_hazir_o,
  input  logic [ADRES_BIT-1:0]             istek_adres_i,
  input  logic                             istek_yaz_i,
  input  logic [VERI_BIT-1:0]              istek_veri_i,
  input  logic [VERI_BIT/8-1:0]            istek_maske_i,
  output logic                             yanit_gecerli_o,
  output logic [VERI_BIT-1:0]              yanit_veri_o,
  output logic                             yanit_hata_o,
  output logic [BOLGE_SAYISI-1:0]          bolge_gecerli_o,
  input  logic [BOLGE_SAYISI-1:0]          bolge_hazir_i,
  output logic [ADRES_BIT-1:0]             bolge_adres_o,
  output logic                             bolge_yaz_o,
  output logic [VERI_BIT-1:0]              bolge_veri_o,
  output logic [VERI_BIT/8-1:0]            bolge_maske_o,
  input  logic [BOLGE_SAYISI-1:0]          bolge_yanit_gecerli_i,
  input  logic [BOLGE_SAYISI*VERI_BIT-1:0] bolge_yanit_veri_i
);

  localparam int CW = $clog2(ZAMAN_ASIMI + 1);

  typedef enum logic [1:0] {BOSTA, ISTEK, YANIT} durum_t;
  durum_t durum, durum_n;

  logic [BOLGE_SAYISI-1:0] isabet, isabet_oh, sec;
  logic [VERI_BIT-1:0]     veri_sec;
  logic [CW-1:0]           sayac;
  logic                    hazir_sec, yanit_sec, zaman_doldu;
  logic                    kabul, tamam, asim;

  // Address decode; walking downward lets the lowest hit index overwrite.
  always_comb begin
    isabet    = '0;
    isabet_oh = '0;
    for (int i = 0; i < BOLGE_SAYISI; i++)
      isabet[i] = (istek_adres_i & BOLGE_MASKE[i*ADRES_BIT +: ADRES_BIT])
                  == BOLGE_TABAN[i*ADRES_BIT +: ADRES_BIT];
    for (int i = BOLGE_SAYISI - 1; i >= 0; i--)
      if (isabet[i]) begin
        isabet_oh    = '0;
        isabet_oh[i] = 1'b1;
      end
  end

  // Only the selected slave's handshake and data are observed.
  always_comb begin
    veri_sec = '0;
    for (int i = 0; i < BOLGE_SAYISI; i++)
      if (sec[i]) veri_sec = bolge_yanit_veri_i[i*VERI_BIT +: VERI_BIT];
  end

  assign hazir_sec     = |(bolge_hazir_i & sec);
  assign yanit_sec     = |(bolge_yanit_gecerli_i & sec);
  assign zaman_doldu   = (sayac >= CW'(ZAMAN_ASIMI - 1));
  assign istek_hazir_o = (durum == BOSTA);

  always_comb begin
    durum_n = durum;
    kabul   = 1'b0;
    tamam   = 1'b0;
    asim    = 1'b0;
    case (durum)
      BOSTA: if (istek_gecerli_i) begin
        kabul = 1'b1;
        if (|isabet) durum_n = ISTEK;
      end
      // Timeout takes priority over a handshake landing on the same edge:
      // the transaction is aborted before the slave owns it.
      ISTEK: if (zaman_doldu) begin
        asim    = 1'b1;
        durum_n = BOSTA;
      end else if (hazir_sec) begin
        durum_n = YANIT;
      end
      // A response on the timeout edge still completes normally.
      YANIT: if (yanit_sec) begin
        tamam   = 1'b1;
        durum_n = BOSTA;
      end else if (zaman_doldu) begin
        asim    = 1'b1;
        durum_n = BOSTA;
      end
      default: durum_n = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum           <= BOSTA;
      yanit_gecerli_o <= 1'b0;
      yanit_hata_o    <= 1'b0;
      yanit_veri_o    <= '0;
      bolge_gecerli_o <= '0;
      bolge_adres_o   <= '0;
      bolge_yaz_o     <= 1'b0;
      bolge_veri_o    <= '0;
      bolge_maske_o   <= '0;
      sec             <= '0;
      sayac           <= '0;
    end else begin
      durum           <= durum_n;
      yanit_gecerli_o <= 1'b0;
      yanit_hata_o    <= 1'b0;
      yanit_veri_o    <= '0;
      if (kabul) begin
        bolge_adres_o <= istek_adres_i;
        bolge_yaz_o   <= istek_yaz_i;
        bolge_veri_o  <= istek_veri_i;
        bolge_maske_o <= istek_maske_i;
        sec           <= isabet_oh;
        sayac         <= '0;
        if (!(|isabet)) begin
          yanit_gecerli_o <= 1'b1;
          yanit_hata_o    <= 1'b1;
        end
      end else if (durum != BOSTA && sayac != {CW{1'b1}}) begin
        sayac <= sayac + CW'(1);
      end
      // Request valid lives exactly as long as the ISTEK state.
      if (durum_n != ISTEK)  bolge_gecerli_o <= '0;
      else if (kabul)        bolge_gecerli_o <= isabet_oh;
      if (tamam) begin
        yanit_gecerli_o <= 1'b1;
        yanit_veri_o    <= bolge_yaz_o ? '0 : veri_sec;
      end
      if (asim) begin
        yanit_gecerli_o <= 1'b1;
        yanit_hata_o    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adres_yonlendirici.sv
// Bench for adres_yonlendirici: three regions, ZAMAN_ASIMI = 8.
// Table vectors, hand sequences (reset mid-transaction, late response,
// back-to-back) and random transactions checked against a transaction model.
module tb_adres_yonlendirici;

  localparam int NB = 3;
  localparam int ZA = 8;
  localparam logic [31:0] TABAN [NB] = '{32'h4000_0000, 32'h0000_0000, 32'h8000_0000};
  localparam logic [31:0] MASKE [NB] = '{32'hC000_0000, 32'hC000_0000, 32'hC000_0000};

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            istek_gecerli = 1'b0;
  logic            istek_hazir;
  logic [31:0]     istek_adres = '0;
  logic            istek_yaz = 1'b0;
  logic [31:0]     istek_veri = '0;
  logic [3:0]      istek_maske = '0;
  logic            yanit_gecerli;
  logic [31:0]     yanit_veri;
  logic            yanit_hata;
  logic [NB-1:0]   bolge_gecerli;
  logic [NB-1:0]   bolge_hazir = '0;
  logic [31:0]     bolge_adres;
  logic            bolge_yaz;
  logic [31:0]     bolge_veri;
  logic [3:0]      bolge_maske;
  logic [NB-1:0]   bolge_yanit_gecerli = '0;
  logic [NB*32-1:0] bolge_yanit_veri = '0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  adres_yonlendirici #(
    .BOLGE_SAYISI(NB), .ADRES_BIT(32), .VERI_BIT(32),
    .BOLGE_TABAN({32'h8000_0000, 32'h0000_0000, 32'h4000_0000}),
    .BOLGE_MASKE({3{32'hC000_0000}}),
    .ZAMAN_ASIMI(ZA)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .istek_gecerli_i(istek_gecerli), .istek_hazir_o(istek_hazir),
    .istek_adres_i(istek_adres), .istek_yaz_i(istek_yaz),
    .istek_veri_i(istek_veri), .istek_maske_i(istek_maske),
    .yanit_gecerli_o(yanit_gecerli), .yanit_veri_o(yanit_veri), .yanit_hata_o(yanit_hata),
    .bolge_gecerli_o(bolge_gecerli), .bolge_hazir_i(bolge_hazir),
    .bolge_adres_o(bolge_adres), .bolge_yaz_o(bolge_yaz),
    .bolge_veri_o(bolge_veri), .bolge_maske_o(bolge_maske),
    .bolge_yanit_gecerli_i(bolge_yanit_gecerli), .bolge_yanit_veri_i(bolge_yanit_veri)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode: first region whose masked address equals its base.
  function automatic int region_of(input logic [31:0] a);
    for (int i = 0; i < NB; i++)
      if ((a & MASKE[i]) == TABAN[i]) return i;
    return -1;
  endfunction

  // One transaction, starting and ending at a negedge with the router idle.
  // The slave raises ready in cycle d1 and answers r cycles after the handshake.
  task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] m, input logic [31:0] rd, input int d1, input int r,
                     input int sel, input logic eerr, input logic [31:0] edat, input int ecyc);
    logic [NB-1:0] oh;
    bit hs;
    int hs_cyc;
    oh = '0;
    if (sel >= 0) oh[sel] = 1'b1;
    for (int k = 0; k < NB; k++)
      bolge_yanit_veri[k*32 +: 32] = (k == sel) ? rd : $urandom;
    chk("hazir_idle", istek_hazir, 1'b1);
    istek_gecerli = 1'b1; istek_adres = a; istek_yaz = w; istek_veri = d; istek_maske = m;
    @(negedge clk);
    istek_gecerli = 1'b0; istek_adres = $urandom; istek_veri = $urandom;
    hs = 0; hs_cyc = 0;
    for (int cyc = 0; cyc <= ecyc; cyc++) begin
      chk("bolge_gecerli", bolge_gecerli, (sel >= 0 && cyc <= d1 && cyc <= ZA - 1) ? oh : '0);
      if (bolge_gecerli != 0) begin
        chk("bolge_adres", bolge_adres, a);
        chk("bolge_yaz", bolge_yaz, w);
        chk("bolge_veri", bolge_veri, d);
        chk("bolge_maske", bolge_maske, m);
      end
      chk("yanit_gecerli", yanit_gecerli, cyc == ecyc);
      if (cyc == ecyc) begin
        chk("yanit_hata", yanit_hata, eerr);
        chk("yanit_veri", yanit_veri, edat);
        chk("hazir_on_pulse", istek_hazir, 1'b1);
        bolge_hazir = '0;
        bolge_yanit_gecerli = '0;
      end else begin
        bolge_hazir = $urandom;
        bolge_yanit_gecerli = $urandom;
        if (sel >= 0) begin
          bolge_hazir[sel] = !hs && cyc >= d1;
          bolge_yanit_gecerli[sel] = hs && cyc == hs_cyc + r;
          if (!hs && bolge_gecerli[sel] && bolge_hazir[sel]) begin
            hs = 1; hs_cyc = cyc + 1;
          end
        end
        @(negedge clk);
      end
    end
    @(negedge clk);
    chk("pulse_drop", yanit_gecerli, 1'b0);
  endtask

  typedef struct {
    logic [31:0] a; logic w; logic [31:0] d; logic [3:0] m; logic [31:0] rd;
    int d1; int r; int sel; logic err; logic [31:0] edat; int cyc;
  } vec_t;
  vec_t tbl [8];

  initial begin
    tbl = '{
      '{32'h4000_0010, 1'b0, 32'h0,         4'hF,    32'hDEAD_BEEF, 0, 0,  0, 1'b0, 32'hDEAD_BEEF, 2},
      '{32'h0000_0100, 1'b1, 32'h1234_5678, 4'b0011, 32'h5555_5555, 4, 0,  1, 1'b0, 32'h0,         6},
      '{32'hC000_0000, 1'b0, 32'h0,         4'hF,    32'h1111_1111, 0, 0, -1, 1'b1, 32'h0,         0},
      '{32'h8000_0004, 1'b0, 32'h0,         4'hF,    32'hCAFE_F00D, 1, 2,  2, 1'b0, 32'hCAFE_F00D, 5},
      '{32'h7FFF_FFFC, 1'b0, 32'h0,         4'hF,    32'h0BAD_F00D, 3, 3,  0, 1'b0, 32'h0BAD_F00D, 8},
      '{32'hBFFF_0000, 1'b1, 32'hAAAA_0000, 4'hC,    32'h2222_2222, 2, 5,  2, 1'b1, 32'h0,         8},
      '{32'h3FFF_FFFF, 1'b0, 32'h0,         4'h1,    32'h3333_3333, 7, 0,  1, 1'b1, 32'h0,         8},
      '{32'hFFFF_FFFF, 1'b0, 32'h0,         4'hF,    32'h4444_4444, 0, 0, -1, 1'b1, 32'h0,         0}
    };

    repeat (3) @(negedge clk);
    chk("rst_yanit_gecerli", yanit_gecerli, 1'b0);
    chk("rst_bolge_gecerli", bolge_gecerli, '0);
    chk("rst_hazir", istek_hazir, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i])
      txn(tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].m, tbl[i].rd, tbl[i].d1, tbl[i].r,
          tbl[i].sel, tbl[i].err, tbl[i].edat, tbl[i].cyc);

    // Reset while waiting in YANIT: everything clears, no response afterwards.
    istek_gecerli = 1'b1; istek_adres = 32'h4000_0020; istek_yaz = 1'b1;
    istek_veri = 32'h9999_8888; istek_maske = 4'hF;
    @(negedge clk);
    istek_gecerli = 1'b0; bolge_hazir = 3'b001;
    @(negedge clk);
    bolge_hazir = '0;
    @(negedge clk);
    chk("pre_rst_in_flight", istek_hazir, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_yanit_gecerli", yanit_gecerli, 1'b0);
    chk("arst_yanit_hata", yanit_hata, 1'b0);
    chk("arst_yanit_veri", yanit_veri, '0);
    chk("arst_bolge_gecerli", bolge_gecerli, '0);
    chk("arst_adres", bolge_adres, '0);
    chk("arst_veri", bolge_veri, '0);
    chk("arst_maske", bolge_maske, '0);
    chk("arst_yaz", bolge_yaz, 1'b0);
    chk("arst_hazir", istek_hazir, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    bolge_yanit_gecerli = 3'b001;
    @(negedge clk);
    bolge_yanit_gecerli = '0;
    for (int k = 0; k < 3; k++) begin
      chk("post_rst_no_pulse", yanit_gecerli, 1'b0);
      chk("post_rst_hazir", istek_hazir, 1'b1);
      @(negedge clk);
    end

    // Slave never answers: timeout error, then a late response is ignored.
    txn(32'h0000_0040, 1'b0, 32'h0, 4'hF, 32'h7777_7777, 0, 30, 1, 1'b1, 32'h0, ZA);
    bolge_yanit_gecerli = 3'b010;
    @(negedge clk);
    bolge_yanit_gecerli = '0;
    chk("late_ignored", yanit_gecerli, 1'b0);
    @(negedge clk);
    chk("late_ignored2", yanit_gecerli, 1'b0);
    chk("late_hazir", istek_hazir, 1'b1);

    // Back-to-back: second request held valid, accepted on the first response pulse.
    bolge_yanit_veri = {32'h0, 32'hFFFF_0000, 32'h0102_0304};
    istek_gecerli = 1'b1; istek_adres = 32'h4000_0000; istek_yaz = 1'b0;
    istek_veri = 32'h0; istek_maske = 4'hF;
    @(negedge clk);
    istek_adres = 32'h0000_0200; istek_yaz = 1'b1; istek_veri = 32'hABCD_0123; istek_maske = 4'h6;
    chk("b2b_sel0", bolge_gecerli, 3'b001);
    chk("b2b_busy", istek_hazir, 1'b0);
    bolge_hazir = 3'b001;
    @(negedge clk);
    bolge_hazir = '0; bolge_yanit_gecerli = 3'b001;
    chk("b2b_drop0", bolge_gecerli, '0);
    @(negedge clk);
    bolge_yanit_gecerli = '0;
    chk("b2b_pulse1", yanit_gecerli, 1'b1);
    chk("b2b_data1", yanit_veri, 32'h0102_0304);
    chk("b2b_hazir_on_pulse", istek_hazir, 1'b1);
    @(negedge clk);
    istek_gecerli = 1'b0;
    chk("b2b_pulse1_drop", yanit_gecerli, 1'b0);
    chk("b2b_sel1", bolge_gecerli, 3'b010);
    chk("b2b_adres2", bolge_adres, 32'h0000_0200);
    chk("b2b_veri2", bolge_veri, 32'hABCD_0123);
    chk("b2b_maske2", bolge_maske, 4'h6);
    bolge_hazir = 3'b010;
    @(negedge clk);
    bolge_hazir = '0; bolge_yanit_gecerli = 3'b010;
    @(negedge clk);
    bolge_yanit_gecerli = '0;
    chk("b2b_pulse2", yanit_gecerli, 1'b1);
    chk("b2b_hata2", yanit_hata, 1'b0);
    chk("b2b_data2_write", yanit_veri, 32'h0);
    @(negedge clk);
    chk("b2b_pulse2_drop", yanit_gecerli, 1'b0);

    // Random transactions against the transaction-level model.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a, d, rd;
      logic w;
      int d1, r, s, ec;
      logic er;
      a  = {2'($urandom_range(0, 3)), 30'($urandom)};
      w  = 1'($urandom);
      d  = $urandom;
      rd = $urandom;
      d1 = $urandom_range(0, 8);
      r  = $urandom_range(0, 5);
      s  = region_of(a);
      er = (s < 0) || (d1 + r + 1 > ZA - 1);
      ec = (s < 0) ? 0 : (er ? ZA : d1 + r + 2);
      txn(a, w, d, 4'($urandom), rd, d1, r, s, er, (er || w) ? 32'h0 : rd, ec);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
